// File: rtl/bit_frame_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// bit_frame_deserializer_pkg
//   Shared definitions for the serial frame deserializer: FSM state encoding,
//   default parameter values and the idle level of the serial line.
// ----------------------------------------------------------------------------
package bit_frame_deserializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for a start bit (line low)
        ST_DATA  = 2'd1,   // sampling WIDTH data bits, LSB first
        ST_STOP  = 2'd2,   // sampling the stop bit
        ST_BREAK = 2'd3    // bad stop seen, waiting for the line to return high
    } state_e;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_ERR_CNT_W = 8;
    localparam logic        SERIAL_IDLE   = 1'b1;

endpackage : bit_frame_deserializer_pkg

// File: rtl/bit_frame_deserializer_out_buffer.sv
// ----------------------------------------------------------------------------
// bit_frame_out_buffer
//   One-entry valid/ready holding register for received words. A new word is
//   loaded when the buffer is empty or is being drained in the same cycle;
//   otherwise the new word is dropped and a one-cycle overrun pulse is raised.
// Ports
//   clkB        in   clock
//   reset       in   synchronous, active-high
//   commit      in   a complete, well-framed word is available this cycle
//   commit_bits in   the word to load
//   ready       in   consumer accepts the held word this cycle
//   valid       out  bits holds an unconsumed word
//   bits        out  held word (keeps its last value after being consumed)
//   overrun     out  registered pulse: committed word was dropped
// ----------------------------------------------------------------------------
module bit_frame_out_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clkB,
    input  logic             reset,
    input  logic             commit,
    input  logic [WIDTH-1:0] commit_bits,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] bits,
    output logic             overrun
);

    logic             valid_q,   valid_d;
    logic [WIDTH-1:0] bits_q,    bits_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        valid_d   = valid_q;
        bits_d    = bits_q;
        overrun_d = 1'b0;
        if (commit) begin
            if (!valid_q || ready) begin
                valid_d = 1'b1;
                bits_d  = commit_bits;
            end else begin
                overrun_d = 1'b1;   // old word wins, new one is lost
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clkB) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            valid_q   <= 1'b0;
            bits_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            bits_q    <= bits_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid   = valid_q;
    assign bits    = bits_q;
    assign overrun = overrun_q;

endmodule : bit_frame_out_buffer

// File: rtl/bit_frame_deserializer.sv
// ----------------------------------------------------------------------------
// bit_frame_deserializer
//   Frames a 1-bit serial line (start bit, WIDTH data bits LSB first, stop bit)
//   into parallel words presented on a valid/ready output, and reports framing
//   and overrun errors with a saturating error counter.
// Ports
//   clkB          in   clock, one serial sample per cycle
//   reset         in   synchronous, active-high; aborts any frame in flight
//   io_in         in   serial line, idle high
//   io_out_ready  in   consumer accepts the word this cycle
//   io_out_valid  out  io_out_bits holds an unconsumed word
//   io_out_bits   out  received word
//   io_frame_err  out  one-cycle pulse: stop bit sampled low
//   io_overrun    out  one-cycle pulse: good frame dropped, buffer full
//   io_err_count  out  saturating count of frame_err + overrun pulses
// ----------------------------------------------------------------------------
module bit_frame_deserializer
    import bit_frame_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clkB,
    input  logic                 reset,
    input  logic                 io_in,
    input  logic                 io_out_ready,
    output logic                 io_out_valid,
    output logic [WIDTH-1:0]     io_out_bits,
    output logic                 io_frame_err,
    output logic                 io_overrun,
    output logic [ERR_CNT_W-1:0] io_err_count
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e               state_q,     state_d;
    logic [CNT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0]     shift_q,     shift_d;
    logic                 frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic                 commit;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        commit      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (io_in != SERIAL_IDLE) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                shift_d[bit_cnt_q] = io_in;
                bit_cnt_d          = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (io_in == SERIAL_IDLE) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_BREAK;
                end
            end
            ST_BREAK: begin
                // Only leaving on a high line keeps a stuck-low line to a
                // single frame error.
                if (io_in == SERIAL_IDLE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Overrun and frame_err come from the STOP state on different inputs, so
    // at most one of them is high in any cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((frame_err_q || io_overrun) && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clkB) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            // NOTE: the shift register is a plain register, not a memory, so
            // it is reset as well; the output word reads 0 rather than X.
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    bit_frame_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
        .clkB        (clkB),
        .reset       (reset),
        .commit      (commit),
        .commit_bits (shift_q),
        .ready       (io_out_ready),
        .valid       (io_out_valid),
        .bits        (io_out_bits),
        .overrun     (io_overrun)
    );

    assign io_frame_err = frame_err_q;
    assign io_err_count = err_cnt_q;

endmodule : bit_frame_deserializer

// File: tb/tb_bit_frame_deserializer.sv
module tb_bit_frame_deserializer;

    localparam int W = 8;

    logic         clkB = 1'b0;
    logic         reset = 1'b1;
    logic         io_in = 1'b1;
    logic         io_out_ready = 1'b0;
    logic         io_out_valid;
    logic [W-1:0] io_out_bits;
    logic         io_frame_err;
    logic         io_overrun;
    logic [7:0]   io_err_count;

    // Second instance with a 2-bit counter sees identical stimulus.
    logic         s_valid, s_ferr, s_ovr;
    logic [W-1:0] s_bits;
    logic [1:0]   s_err_count;

    int vectors    = 0;
    int miscompares = 0;
    logic [W-1:0] sb[$];

    always #5 clkB = ~clkB;

    bit_frame_deserializer #(.WIDTH(W), .ERR_CNT_W(8)) dut (
        .clkB(clkB), .reset(reset), .io_in(io_in), .io_out_ready(io_out_ready),
        .io_out_valid(io_out_valid), .io_out_bits(io_out_bits),
        .io_frame_err(io_frame_err), .io_overrun(io_overrun),
        .io_err_count(io_err_count)
    );

    bit_frame_deserializer #(.WIDTH(W), .ERR_CNT_W(2)) dut_sat (
        .clkB(clkB), .reset(reset), .io_in(io_in), .io_out_ready(io_out_ready),
        .io_out_valid(s_valid), .io_out_bits(s_bits),
        .io_frame_err(s_ferr), .io_overrun(s_ovr),
        .io_err_count(s_err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a word is popped and compared on every handshake.
    always @(negedge clkB) begin
        if (!reset && io_out_valid && io_out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_pop: got word %0h expected none at %0t", io_out_bits, $time);
            end else begin
                check("sb_word", {24'd0, io_out_bits}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clkB);
        #1;
    endtask

    task automatic do_reset();
        io_in = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Returns just after the edge that samples the stop bit.
    task automatic send_frame(input logic [W-1:0] data, input logic stop);
        io_in = 1'b0;
        tick();
        for (int i = 0; i < W; i++) begin
            io_in = data[i];
            tick();
        end
        io_in = stop;
        tick();
    endtask

    task automatic watch(input int n, output int nv, output int nf, output int no);
        nv = 0; nf = 0; no = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            nv += int'(io_out_valid);
            nf += int'(io_frame_err);
            no += int'(io_overrun);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         stop;
        logic         exp_valid;
        logic         exp_ferr;
        logic [7:0]   exp_errs;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int nv, nf, no;

        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int nv, nf, no;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[5] = '{8'h80, 1'b0, 1'b0, 1'b1, 8'd2};

        // 1: idle line after reset
        do_reset();
        watch(20, nv, nf, no);
        check("idle_valid", nv, 0);
        check("idle_pulses", nf + no, 0);
        check("idle_errcnt", io_err_count, 0);
        check("reset_bits", io_out_bits, 0);

        // Single frames with ready high (first entry is the 0xA5 case)
        io_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].exp_valid) sb.push_back(tbl[i].data);
            send_frame(tbl[i].data, tbl[i].stop);
            check($sformatf("t%0d_valid", i), io_out_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) check($sformatf("t%0d_bits", i), io_out_bits, tbl[i].data);
            check($sformatf("t%0d_ferr", i), io_frame_err, tbl[i].exp_ferr);
            check($sformatf("t%0d_ovr", i), io_overrun, 0);
            io_in = 1'b1;
            tick();
            check($sformatf("t%0d_valid_1cyc", i), io_out_valid, 0);
            tick();
            check($sformatf("t%0d_errcnt", i), io_err_count, tbl[i].exp_errs);
        end

        // 3: back-to-back frames with consumer stalled
        do_reset();
        io_out_ready = 1'b0;
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("b2b_first_valid", io_out_valid, 1);
        check("b2b_first_bits", io_out_bits, 8'h3C);
        check("b2b_first_ovr", io_overrun, 0);
        send_frame(8'hC3, 1'b1);
        check("b2b_overrun", io_overrun, 1);
        check("b2b_held_bits", io_out_bits, 8'h3C);
        check("b2b_held_valid", io_out_valid, 1);
        io_in = 1'b1;
        tick();
        check("b2b_ovr_pulse_end", io_overrun, 0);
        check("b2b_errcnt", io_err_count, 1);
        io_out_ready = 1'b1;
        tick();
        check("b2b_drained", io_out_valid, 0);
        tick();
        check("b2b_stays_empty", io_out_valid, 0);

        // 4: bad stop bit, line stuck low
        send_frame(8'h5A, 1'b0);
        check("brk_ferr", io_frame_err, 1);
        check("brk_valid", io_out_valid, 0);
        watch(14, nv, nf, no);
        check("brk_extra_ferr", nf, 0);
        check("brk_no_valid", nv, 0);
        io_in = 1'b1;
        tick();
        tick();
        check("brk_errcnt", io_err_count, 2);
        sb.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        check("brk_recover_bits", io_out_bits, 8'h01);
        check("brk_recover_valid", io_out_valid, 1);
        io_in = 1'b1;
        tick();

        // 5: reset during data bit 4 of 0xFF
        io_in = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            io_in = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        watch(12, nv, nf, no);
        check("rst_abort_valid", nv, 0);
        check("rst_abort_pulses", nf + no, 0);
        check("rst_abort_errcnt", io_err_count, 0);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("rst_next_bits", io_out_bits, 8'h81);
        io_in = 1'b1;
        tick();

        // 6: saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h33, 1'b0);
            io_in = 1'b1;
            tick();
            if (i == 1) check("sat_mid", s_err_count, 2);
        end
        tick();
        check("sat_wide_errcnt", io_err_count, 5);
        check("sat_narrow_errcnt", s_err_count, 3);

        tick();
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bit_frame_deserializer
